// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared constants for the bit-serial adder.
// State encoding, legal WIDTH bounds and the FSM state type.
package serial_adder_pkg;

  // State encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Legal operand width range and default
  localparam int WIDTH_MIN     = 2;
  localparam int WIDTH_MAX     = 32;
  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT,
    ST_DONE  = DONE
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle of the bit-serial adder.
// The Sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef SERIAL_ADDER_SUB_EN
  logic             Sub;
`endif
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Busy;
  logic             Done;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output Start, A, B, Sub, input Sum, Cout, Busy, Done);
  modport slave  (input Start, A, B, Sub, output Sum, Cout, Busy, Done);
`else
  modport master (output Start, A, B, input Sum, Cout, Busy, Done);
  modport slave  (input Start, A, B, output Sum, Cout, Busy, Done);
`endif

endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder made of two half-adder
// stages with their carries ORed together.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs1;
  logic hc1;
  logic hc2;

  // First half adder: a + b
  assign hs1 = a ^ b;
  assign hc1 = a & b;

  // Second half adder: partial sum + carry in
  assign s   = hs1 ^ ci;
  assign hc2 = hs1 & ci;

  // Carry out from either stage
  assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit unsigned operands LSB-first, one bit per
// clock, through a single full_adder_cell with a registered carry.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds Sub, computing A-B).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic           Clk,
  input  logic           Rst,
  serial_adder_if.slave  bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   a_sh_next;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   b_sh_next;
  logic               carry;
  logic               carry_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   sum_next;
  logic               cout;
  logic               cout_next;
  logic               busy;
  logic               busy_next;
  logic               done;
  logic               done_next;
  logic               sub_sel;
  logic               fa_s;
  logic               fa_co;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = bus.Sub;
`else
  assign sub_sel = 1'b0;
`endif

  full_adder_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state and datapath update: load on accepted Start, shift in SHIFT
  always_comb begin
    state_next = state;
    a_sh_next  = a_sh;
    b_sh_next  = b_sh;
    carry_next = carry;
    cnt_next   = cnt;
    sum_next   = sum;
    cout_next  = cout;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry
          a_sh_next  = bus.A;
          b_sh_next  = sub_sel ? ~bus.B : bus.B;
          carry_next = sub_sel;
          cnt_next   = {CNT_W{1'b0}};
          state_next = ST_SHIFT;
          busy_next  = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_sh_next  = {1'b0, a_sh[WIDTH-1:1]};
        b_sh_next  = {1'b0, b_sh[WIDTH-1:1]};
        carry_next = fa_co;
        sum_next   = {fa_s, sum[WIDTH-1:1]};
        if (cnt == LAST_CNT) begin
          // Last bit: publish carry and pulse Done next cycle
          cnt_next   = {CNT_W{1'b0}};
          cout_next  = fa_co;
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else begin
          cnt_next   = cnt + CNT_W'(1);
          busy_next  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
      a_sh  <= {WIDTH{1'b0}};
      b_sh  <= {WIDTH{1'b0}};
      carry <= 1'b0;
      cnt   <= {CNT_W{1'b0}};
      sum   <= {WIDTH{1'b0}};
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      a_sh  <= a_sh_next;
      b_sh  <= b_sh_next;
      carry <= carry_next;
      cnt   <= cnt_next;
      sum   <= sum_next;
      cout  <= cout_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  assign bus.Sum  = sum;
  assign bus.Cout = cout;
  assign bus.Busy = busy;
  assign bus.Done = done;

endmodule
